// File: rtl/mem_responder.sv
// Single-ported word memory answering instruction fetches and data
// reads/writes one transaction at a time, with a fixed response latency.
module mem_responder #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  // instruction fetch port
  input  logic [31:0] PC,
  input  logic        Inst_Req_Valid,
  output logic        Inst_Req_Ack,
  output logic [31:0] Instruction,
  output logic        Inst_Valid,
  input  logic        Inst_Ack,
  // data port
  input  logic [31:0] Address,
  input  logic        MemWrite,
  input  logic [31:0] Write_data,
  input  logic [3:0]  Write_strb,
  input  logic        MemRead,
  output logic        Mem_Req_Ack,
  output logic [31:0] Read_data,
  output logic        Read_data_Valid,
  input  logic        Read_data_Ack,
  // completed transaction counters
  output logic [31:0] inst_cnt,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAT_LD = CNT_W'(LATENCY);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    I_WAIT = 3'd1,
    I_RESP = 3'd2,
    D_WAIT = 3'd3,
    D_RESP = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  wait_q, wait_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [31:0]       instr_d, rdata_d;
  logic              ivld_d, dvld_d;
  logic [31:0]       inst_cnt_d, rd_cnt_d, wr_cnt_d;

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] pc_idx, addr_idx;
  logic              idle, wr_en;
  logic              unused_addr_bits;

  // Word index from byte address; low and high bits ignored so addresses wrap
  assign pc_idx   = PC[ADDR_W+1:2];
  assign addr_idx = Address[ADDR_W+1:2];
  assign unused_addr_bits = ^{PC[31:ADDR_W+2], PC[1:0],
                              Address[31:ADDR_W+2], Address[1:0]};

  // Request acceptance: data port wins over fetch, only in IDLE, never in reset
  assign idle         = rst && (state_q == IDLE);
  assign Mem_Req_Ack  = idle && (MemRead || MemWrite);
  assign Inst_Req_Ack = idle && Inst_Req_Valid && !MemRead && !MemWrite;
  assign wr_en        = idle && MemWrite;

  // Byte-lane writes; memory contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (Write_strb[i]) mem[addr_idx][8*i +: 8] <= Write_data[8*i +: 8];
      end
    end
  end

  // Next-state, response data and counter update
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    idx_d      = idx_q;
    instr_d    = Instruction;
    rdata_d    = Read_data;
    ivld_d     = Inst_Valid;
    dvld_d     = Read_data_Valid;
    inst_cnt_d = inst_cnt;
    rd_cnt_d   = rd_cnt;
    wr_cnt_d   = wr_cnt;
    case (state_q)
      IDLE: begin
        if (MemWrite) begin
          // a simultaneous read is dropped
          wr_cnt_d = wr_cnt + 32'd1;
        end else if (MemRead) begin
          idx_d = addr_idx;
          if (LATENCY == 0) begin
            state_d = D_RESP;
            rdata_d = mem[addr_idx];
            dvld_d  = 1'b1;
          end else begin
            state_d = D_WAIT;
            wait_d  = LAT_LD;
          end
        end else if (Inst_Req_Valid) begin
          idx_d = pc_idx;
          if (LATENCY == 0) begin
            state_d = I_RESP;
            instr_d = mem[pc_idx];
            ivld_d  = 1'b1;
          end else begin
            state_d = I_WAIT;
            wait_d  = LAT_LD;
          end
        end
      end
      I_WAIT: begin
        wait_d = wait_q - CNT_W'(1);
        if (wait_q == CNT_W'(1)) begin
          state_d = I_RESP;
          instr_d = mem[idx_q];
          ivld_d  = 1'b1;
        end
      end
      D_WAIT: begin
        wait_d = wait_q - CNT_W'(1);
        if (wait_q == CNT_W'(1)) begin
          state_d = D_RESP;
          rdata_d = mem[idx_q];
          dvld_d  = 1'b1;
        end
      end
      I_RESP: begin
        if (Inst_Ack) begin
          state_d    = IDLE;
          ivld_d     = 1'b0;
          inst_cnt_d = inst_cnt + 32'd1;
        end
      end
      D_RESP: begin
        if (Read_data_Ack) begin
          state_d  = IDLE;
          dvld_d   = 1'b0;
          rd_cnt_d = rd_cnt + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any transaction in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      wait_q          <= '0;
      idx_q           <= '0;
      Instruction     <= '0;
      Read_data       <= '0;
      Inst_Valid      <= 1'b0;
      Read_data_Valid <= 1'b0;
      inst_cnt        <= '0;
      rd_cnt          <= '0;
      wr_cnt          <= '0;
    end else begin
      state_q         <= state_d;
      wait_q          <= wait_d;
      idx_q           <= idx_d;
      Instruction     <= instr_d;
      Read_data       <= rdata_d;
      Inst_Valid      <= ivld_d;
      Read_data_Valid <= dvld_d;
      inst_cnt        <= inst_cnt_d;
      rd_cnt          <= rd_cnt_d;
      wr_cnt          <= wr_cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed table, corner sequences, random traffic
// against a word-array model, plus a zero-latency instance.
module tb_mem_responder;

  localparam int unsigned AW  = 12;
  localparam int unsigned LAT = 2;

  logic        clk, rst;
  logic [31:0] PC, Instruction, Address, Write_data, Read_data;
  logic        Inst_Req_Valid, Inst_Req_Ack, Inst_Valid, Inst_Ack;
  logic        MemWrite, MemRead, Mem_Req_Ack, Read_data_Valid, Read_data_Ack;
  logic [3:0]  Write_strb;
  logic [31:0] inst_cnt, rd_cnt, wr_cnt;

  // zero-latency instance signals
  logic [31:0] z_pc, z_ins, z_addr, z_wd, z_rd, z_ic, z_rc, z_wc;
  logic        z_irv, z_ira, z_iv, z_ia, z_mw, z_mr, z_mra, z_rdv, z_rda;
  logic [3:0]  z_ws;

  mem_responder #(.ADDR_W(AW), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .PC(PC), .Inst_Req_Valid(Inst_Req_Valid), .Inst_Req_Ack(Inst_Req_Ack),
    .Instruction(Instruction), .Inst_Valid(Inst_Valid), .Inst_Ack(Inst_Ack),
    .Address(Address), .MemWrite(MemWrite), .Write_data(Write_data),
    .Write_strb(Write_strb), .MemRead(MemRead), .Mem_Req_Ack(Mem_Req_Ack),
    .Read_data(Read_data), .Read_data_Valid(Read_data_Valid),
    .Read_data_Ack(Read_data_Ack),
    .inst_cnt(inst_cnt), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
  );

  mem_responder #(.ADDR_W(12), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .PC(z_pc), .Inst_Req_Valid(z_irv), .Inst_Req_Ack(z_ira),
    .Instruction(z_ins), .Inst_Valid(z_iv), .Inst_Ack(z_ia),
    .Address(z_addr), .MemWrite(z_mw), .Write_data(z_wd),
    .Write_strb(z_ws), .MemRead(z_mr), .Mem_Req_Ack(z_mra),
    .Read_data(z_rd), .Read_data_Valid(z_rdv), .Read_data_Ack(z_rda),
    .inst_cnt(z_ic), .rd_cnt(z_rc), .wr_cnt(z_wc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {OP_W, OP_R, OP_I, OP_B} op_e;
  typedef struct {
    op_e         op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] ref_mem [4096];
  int unsigned exp_inst, exp_rd, exp_wr;
  int          vec_cnt, err_cnt;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference memory: word index is byte address / 4, modulo 4096 words
  function automatic void ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int unsigned w;
    w = (a / 4) % 4096;
    for (int i = 0; i < 4; i++)
      if (s[i]) ref_mem[w][8*i +: 8] = d[8*i +: 8];
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem[(a / 4) % 4096];
  endfunction

  function automatic logic [31:0] rand_addr(input int unsigned w);
    return ($urandom & 32'hFFFF_C000) | (32'(w) << 2) | ($urandom & 32'h3);
  endfunction

  task automatic idle_inputs();
    PC = '0; Inst_Req_Valid = 0; Inst_Ack = 0;
    Address = '0; MemWrite = 0; Write_data = '0; Write_strb = '0;
    MemRead = 0; Read_data_Ack = 0;
  endtask

  // Cycles from acceptance (cycle 0) until valid is seen, bounded
  task automatic wait_valid(input bit inst, output int cyc);
    cyc = 1;
    while (!(inst ? Inst_Valid : Read_data_Valid) && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    Address = a; Write_data = d; Write_strb = s; MemWrite = 1;
    #1 check("wr_ack", 32'(Mem_Req_Ack), 32'd1);
    @(posedge clk);
    @(negedge clk);
    MemWrite = 0;
    ref_write(a, d, s);
    exp_wr++;
    check("wr_cnt", wr_cnt, exp_wr);
  endtask

  // Read or fetch; response held for 'hold' cycles before acknowledging
  task automatic xact(input bit inst, input logic [31:0] a, input int hold, input logic [31:0] exp);
    int          cyc;
    logic [31:0] first;
    @(negedge clk);
    if (inst) begin PC = a; Inst_Req_Valid = 1; end
    else begin Address = a; MemRead = 1; end
    #1 check(inst ? "inst_req_ack" : "mem_req_ack",
             32'(inst ? Inst_Req_Ack : Mem_Req_Ack), 32'd1);
    @(posedge clk);
    @(negedge clk);
    Inst_Req_Valid = 0; MemRead = 0;
    wait_valid(inst, cyc);
    check(inst ? "inst_latency" : "rd_latency", 32'(cyc), 32'(LAT + 1));
    if (cyc >= 40) return;
    first = inst ? Instruction : Read_data;
    check(inst ? "instruction" : "read_data", first, exp);
    for (int h = 0; h < hold; h++) begin
      MemRead = 1; Inst_Req_Valid = 1; Address = $urandom; PC = $urandom;
      #1 check("resp_acks", 32'({Mem_Req_Ack, Inst_Req_Ack}), 32'd0);
      check("resp_valid", 32'(inst ? Inst_Valid : Read_data_Valid), 32'd1);
      check("resp_stable", inst ? Instruction : Read_data, first);
      @(negedge clk);
    end
    MemRead = 0; Inst_Req_Valid = 0;
    if (inst) Inst_Ack = 1; else Read_data_Ack = 1;
    @(posedge clk);
    @(negedge clk);
    Inst_Ack = 0; Read_data_Ack = 0;
    if (inst) exp_inst++; else exp_rd++;
    check("valid_drop", 32'(inst ? Inst_Valid : Read_data_Valid), 32'd0);
    check(inst ? "inst_cnt" : "rd_cnt", inst ? inst_cnt : rd_cnt, inst ? exp_inst : exp_rd);
  endtask

  // Read and write together: write lands, read is silently dropped
  task automatic do_both(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    Address = a; Write_data = d; Write_strb = s; MemWrite = 1; MemRead = 1;
    #1 check("both_ack", 32'(Mem_Req_Ack), 32'd1);
    @(posedge clk);
    @(negedge clk);
    MemWrite = 0; MemRead = 0;
    ref_write(a, d, s);
    exp_wr++;
    for (int k = 0; k < LAT + 3; k++) begin
      check("both_no_resp", 32'(Read_data_Valid), 32'd0);
      @(negedge clk);
    end
    check("both_rd_cnt", rd_cnt, exp_rd);
    check("both_wr_cnt", wr_cnt, exp_wr);
  endtask

  initial begin
    int          cyc;
    int unsigned w;
    vec_cnt = 0; err_cnt = 0;
    exp_inst = 0; exp_rd = 0; exp_wr = 0;
    foreach (ref_mem[i]) ref_mem[i] = '0;
    idle_inputs();
    z_pc = '0; z_irv = 0; z_ia = 0; z_addr = '0; z_mw = 0; z_wd = '0;
    z_ws = '0; z_mr = 0; z_rda = 0;

    // reset behaviour: outputs cleared and requests ignored
    rst = 1;
    #1 rst = 0;
    MemRead = 1; Inst_Req_Valid = 1;
    #2;
    check("rst_acks", 32'({Mem_Req_Ack, Inst_Req_Ack}), 32'd0);
    check("rst_valids", 32'({Inst_Valid, Read_data_Valid}), 32'd0);
    check("rst_instr", Instruction, 32'd0);
    check("rst_rdata", Read_data, 32'd0);
    check("rst_cnts", inst_cnt | rd_cnt | wr_cnt, 32'd0);
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1;

    // directed table
    tbl.push_back('{op: OP_W, addr: 32'h100,  data: 32'hAABBCCDD, strb: 4'hF, exp: 32'h0});
    tbl.push_back('{op: OP_W, addr: 32'h100,  data: 32'h00001100, strb: 4'h2, exp: 32'h0});
    tbl.push_back('{op: OP_R, addr: 32'h102,  data: 32'h0,        strb: 4'h0, exp: 32'hAABB11DD});
    tbl.push_back('{op: OP_W, addr: 32'h000,  data: 32'h00000013, strb: 4'hF, exp: 32'h0});
    tbl.push_back('{op: OP_I, addr: 32'h000,  data: 32'h0,        strb: 4'h0, exp: 32'h00000013});
    tbl.push_back('{op: OP_W, addr: 32'h4004, data: 32'h11223344, strb: 4'hF, exp: 32'h0});
    tbl.push_back('{op: OP_R, addr: 32'h005,  data: 32'h0,        strb: 4'h0, exp: 32'h11223344});
    tbl.push_back('{op: OP_W, addr: 32'h008,  data: 32'hFFFFFFFF, strb: 4'hF, exp: 32'h0});
    tbl.push_back('{op: OP_W, addr: 32'h009,  data: 32'h00000000, strb: 4'h5, exp: 32'h0});
    tbl.push_back('{op: OP_I, addr: 32'h00B,  data: 32'h0,        strb: 4'h0, exp: 32'hFF00FF00});
    tbl.push_back('{op: OP_B, addr: 32'h100,  data: 32'h00000055, strb: 4'h1, exp: 32'h0});
    tbl.push_back('{op: OP_R, addr: 32'h103,  data: 32'h0,        strb: 4'h0, exp: 32'hAABB1155});
    for (int i = 0; i < tbl.size(); i++) begin
      case (tbl[i].op)
        OP_W: do_write(tbl[i].addr, tbl[i].data, tbl[i].strb);
        OP_R: xact(1'b0, tbl[i].addr, i % 3, tbl[i].exp);
        OP_I: xact(1'b1, tbl[i].addr, i % 3, tbl[i].exp);
        default: do_both(tbl[i].addr, tbl[i].data, tbl[i].strb);
      endcase
    end

    // read and fetch requested together: read first, fetch after
    @(negedge clk);
    Address = 32'h0; MemRead = 1; PC = 32'h8; Inst_Req_Valid = 1;
    #1 check("prio_mem_ack", 32'(Mem_Req_Ack), 32'd1);
    check("prio_inst_ack", 32'(Inst_Req_Ack), 32'd0);
    @(posedge clk);
    @(negedge clk);
    MemRead = 0;
    #1 check("prio_busy_ack", 32'(Inst_Req_Ack), 32'd0);
    wait_valid(1'b0, cyc);
    check("prio_rd_lat", 32'(cyc), 32'(LAT + 1));
    check("prio_rdata", Read_data, 32'h00000013);
    Read_data_Ack = 1;
    @(posedge clk);
    @(negedge clk);
    Read_data_Ack = 0;
    exp_rd++;
    #1 check("prio_fetch_ack", 32'(Inst_Req_Ack), 32'd1);
    @(posedge clk);
    @(negedge clk);
    Inst_Req_Valid = 0;
    wait_valid(1'b1, cyc);
    check("prio_if_lat", 32'(cyc), 32'(LAT + 1));
    check("prio_instr", Instruction, 32'hFF00FF00);
    Inst_Ack = 1;
    @(posedge clk);
    @(negedge clk);
    Inst_Ack = 0;
    exp_inst++;
    check("prio_inst_cnt", inst_cnt, exp_inst);
    check("prio_rd_cnt", rd_cnt, exp_rd);

    // initiator stalls response for 5 cycles
    xact(1'b0, 32'h4100, 5, 32'hAABB1155);

    // random traffic over words 64..95 with random don't-care address bits
    for (int k = 0; k < 32; k++)
      do_write(rand_addr(64 + k), $urandom, 4'hF);
    for (int n = 0; n < 60; n++) begin
      w = 64 + $urandom_range(0, 31);
      case ($urandom_range(0, 2))
        0: do_write(rand_addr(w), $urandom, 4'($urandom));
        1: xact(1'b0, rand_addr(w), $urandom_range(0, 2), ref_mem[w]);
        default: xact(1'b1, rand_addr(w), $urandom_range(0, 2), ref_mem[w]);
      endcase
    end

    // reset between edges while a read is waiting
    @(negedge clk);
    Address = 32'h100; MemRead = 1;
    @(posedge clk);
    @(negedge clk);
    MemRead = 0;
    #2 rst = 0;
    #1 check("midrst_valid", 32'(Read_data_Valid), 32'd0);
    check("midrst_rdata", Read_data, 32'd0);
    check("midrst_instr", Instruction, 32'd0);
    check("midrst_rd_cnt", rd_cnt, 32'd0);
    check("midrst_cnts", inst_cnt | wr_cnt, 32'd0);
    MemRead = 1; Inst_Req_Valid = 1;
    #1 check("midrst_acks", 32'({Mem_Req_Ack, Inst_Req_Ack}), 32'd0);
    @(posedge clk);
    #2 rst = 1;
    MemRead = 0; Inst_Req_Valid = 0;
    exp_inst = 0; exp_rd = 0; exp_wr = 0;
    for (int k = 0; k < LAT + 3; k++) begin
      @(negedge clk);
      check("postrst_no_resp", 32'(Read_data_Valid), 32'd0);
    end
    xact(1'b0, 32'h102, 0, ref_read(32'h100));
    xact(1'b1, 32'h4000, 1, ref_read(32'h0));

    // zero-latency instance: address 0x4000 wraps to word 0
    @(negedge clk);
    z_addr = 32'h0; z_wd = 32'hCAFEF00D; z_ws = 4'hF; z_mw = 1;
    @(posedge clk);
    @(negedge clk);
    z_mw = 0;
    z_addr = 32'h4000; z_mr = 1; z_rda = 1;
    #1 check("z_mem_ack", 32'(z_mra), 32'd1);
    @(posedge clk);
    @(negedge clk);
    z_mr = 0;
    check("z_rd_valid", 32'(z_rdv), 32'd1);
    check("z_rdata", z_rd, 32'hCAFEF00D);
    @(posedge clk);
    @(negedge clk);
    z_rda = 0;
    check("z_rd_done", 32'(z_rdv), 32'd0);
    check("z_rd_cnt", z_rc, 32'd1);
    z_pc = 32'h4000; z_irv = 1; z_ia = 1;
    #1 check("z_inst_ack", 32'(z_ira), 32'd1);
    @(posedge clk);
    @(negedge clk);
    z_irv = 0;
    check("z_inst_valid", 32'(z_iv), 32'd1);
    check("z_instr", z_ins, 32'hCAFEF00D);
    @(posedge clk);
    @(negedge clk);
    z_ia = 0;
    check("z_inst_done", 32'(z_iv), 32'd0);
    check("z_inst_cnt", z_ic, 32'd1);
    check("z_wr_cnt", z_wc, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
